sata_rx_drain_ctrl: RTL

Read-side controller for the SATA receive buffer. It runs in the buffer's read clock domain and pops 37-bit words with a one-cycle read latency. Each word is classified into frames, and accepted words go to a valid/ready stream for the transport layer. It also drives HOLD-request hysteresis from the buffer's high/low flags and handles flush and over-length frames.

---
 rtl/sata_rx_pkg.sv | 31 +++
 rtl/sata_rx_drain_ctrl_skid.sv | 52 +++++
 rtl/sata_rx_drain_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sata_rx_pkg.sv
// Shared types and constants for the SATA receive-buffer drain controller.
package sata_rx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FRAME   = 2'd1,
    DISCARD = 2'd2,
    FLUSH   = 2'd3
  } rx_state_e;

  localparam int WORD_W  = 37;
  localparam int SOF     = 32;
  localparam int EOF     = 33;
  localparam int CRC_ERR = 34;
  localparam int DEC_ERR = 35;

  typedef logic [WORD_W-1:0] rx_word_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    logic        err;
  } skid_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(logic [15:0] v, logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/sata_rx_drain_ctrl_skid.sv
// Two-entry output FIFO for the drain controller. Entries are classified
// words; the head is presented combinationally and is zero when empty.
module sata_rx_skid
  import sata_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        push_i,
  input  skid_entry_t push_data_i,
  input  logic        pop_i,
  output logic        valid_o,
  output skid_entry_t head_o,
  output logic [1:0]  count_o
);

  skid_entry_t slot0_q, slot1_q;
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        do_push, do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  // Storage, pointers and occupancy; clear drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) slot1_q <= push_data_i;
        else          slot0_q <= push_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;
  assign head_o  = !valid_o ? '0 : (rd_ptr_q ? slot1_q : slot0_q);

endmodule

// File: rtl/sata_rx_drain_ctrl.sv
// Read-side drain controller for the SATA receive buffer: pops words with a
// one-cycle read latency, frames them into a valid/ready stream, drives HOLD
// hysteresis and handles flush / over-length frames.
// Optional statistics counters: define SATA_RX_DRAIN_STATS_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | between frames; non-sof words are orphans and dropped
// FRAME   | inside a frame; words stored, error flag accumulated
// DISCARD | frame was cut short; drop words up to and including eof
// FLUSH   | drop skid and in-flight data, drain buffer until empty
module sata_rx_drain_ctrl
  import sata_rx_pkg::*;
#(
  parameter int MAX_FRAME_WORDS     = 2049,
  parameter bit HOLD_RELEASE_ON_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        buf_en_rd,
  input  logic [36:0] buf_data_rd,
  input  logic        buf_empty_rd,
  input  logic        buf_high_rd,
  input  logic        buf_low_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic        hold_req,
  input  logic        flush,
  output logic        flush_busy
`ifdef SATA_RX_DRAIN_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_err_frames,
  output logic [15:0] stat_orphans,
  output logic [15:0] stat_overlen
`endif
);

  localparam int             CNT_W   = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_WORDS);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_acc_q, err_acc_d;
  logic             inflight_q, run_q, hold_q;

  logic             w_sof, w_eof, w_err;
  logic             push, pop, skid_clear, skid_valid, rd_space;
  logic             orphan_ev, overlen_ev;
  logic [1:0]       skid_cnt, occ;
  skid_entry_t      push_ent, head;
  logic             unused_rsvd;

  assign w_sof       = buf_data_rd[SOF];
  assign w_eof       = buf_data_rd[EOF];
  assign w_err       = buf_data_rd[CRC_ERR] | buf_data_rd[DEC_ERR];
  assign unused_rsvd = buf_data_rd[36];
  assign cnt_inc     = cnt_q + 1'b1;

  assign pop      = skid_valid & out_ready;
  assign occ      = skid_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_space = (occ < 2'd2);
  // While flushing the skid is irrelevant, so reads only wait for data.
  assign buf_en_rd = run_q & ~buf_empty_rd & ((state_q == FLUSH) | rd_space);

  assign skid_clear = (state_q == FLUSH) | flush;

  // Classify the word arriving from the buffer and pick the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_acc_d  = err_acc_q;
    push       = 1'b0;
    push_ent   = '0;
    orphan_ev  = 1'b0;
    overlen_ev = 1'b0;
    push_ent.data = buf_data_rd[31:0];
    if (flush && (state_q != FLUSH)) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (inflight_q) begin
            if (w_sof) begin
              push         = 1'b1;
              push_ent.sof = 1'b1;
              cnt_d        = CNT_W'(1);
              err_acc_d    = w_err;
              if (w_eof) begin
                push_ent.eof = 1'b1;
                push_ent.err = w_err;
              end else if (MAX_FRAME_WORDS <= 1) begin
                push_ent.eof = 1'b1;
                push_ent.err = 1'b1;
                overlen_ev   = 1'b1;
                state_d      = DISCARD;
              end else begin
                state_d = FRAME;
              end
            end else begin
              orphan_ev = 1'b1;
            end
          end
        end
        FRAME: begin
          if (inflight_q) begin
            push  = 1'b1;
            cnt_d = cnt_inc;
            if (w_eof) begin
              push_ent.eof = 1'b1;
              push_ent.err = err_acc_q | w_err;
              state_d      = IDLE;
            end else if (w_sof) begin
              // A new sof cuts the open frame; the new frame is dropped too.
              push_ent.eof = 1'b1;
              push_ent.err = 1'b1;
              state_d      = DISCARD;
            end else if (cnt_inc == CNT_MAX) begin
              push_ent.eof = 1'b1;
              push_ent.err = 1'b1;
              overlen_ev   = 1'b1;
              state_d      = DISCARD;
            end else begin
              err_acc_d = err_acc_q | w_err;
            end
          end
        end
        DISCARD: begin
          if (inflight_q && w_eof) state_d = IDLE;
        end
        FLUSH: begin
          if (buf_empty_rd && !inflight_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, frame bookkeeping and read pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_acc_q  <= 1'b0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_acc_q  <= err_acc_d;
      inflight_q <= buf_en_rd;
      run_q      <= 1'b1;
    end
  end

  // HOLD hysteresis: set on high watermark, set wins over release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else if (buf_high_rd) hold_q <= 1'b1;
    else if (HOLD_RELEASE_ON_LOW ? buf_low_rd : 1'b1) hold_q <= 1'b0;
  end

  sata_rx_skid u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (skid_clear),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .valid_o     (skid_valid),
    .head_o      (head),
    .count_o     (skid_cnt)
  );

  assign out_valid  = skid_valid;
  assign out_data   = head.data;
  assign out_sof    = head.sof;
  assign out_eof    = head.eof;
  assign out_err    = head.err;
  assign hold_req   = hold_q;
  assign flush_busy = (state_q == FLUSH);

`ifdef SATA_RX_DRAIN_STATS_EN
  logic [15:0] st_frames_q, st_err_q, st_orph_q, st_ovl_q;

  // Saturating event counters, counted when the classified word is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_frames_q <= '0;
      st_err_q    <= '0;
      st_orph_q   <= '0;
      st_ovl_q    <= '0;
    end else begin
      st_frames_q <= sat_inc(st_frames_q, push & push_ent.eof);
      st_err_q    <= sat_inc(st_err_q, push & push_ent.eof & push_ent.err);
      st_orph_q   <= sat_inc(st_orph_q, orphan_ev);
      st_ovl_q    <= sat_inc(st_ovl_q, overlen_ev);
    end
  end

  assign stat_frames     = st_frames_q;
  assign stat_err_frames = st_err_q;
  assign stat_orphans    = st_orph_q;
  assign stat_overlen    = st_ovl_q;
`else
  logic unused_stat_ev;
  assign unused_stat_ev = orphan_ev | overlen_ev;
`endif

endmodule
